// File: rtl/trigger_piso_module.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock with framing valid and last-bit marker.
module trigger_piso_module #(
  parameter int WIDTH     = 10,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inBus,
  input  logic             inValid,
  output logic             inReady,
  output logic             serOut,
  output logic             serValid,
  output logic             serLast,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             ser_out_nxt, ser_vld_nxt;
  logic             accept;

  // serLast/inReady decode only from flops, so no input reaches an output combinationally
  assign serLast = (state == SHIFT) && (cnt == CNT_LAST);
  assign inReady = (state == IDLE) || serLast;
  assign busy    = serValid;
  assign accept  = inValid && inReady;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    ser_out_nxt = serOut;
    ser_vld_nxt = serValid;
    if (accept) begin
      state_nxt   = SHIFT;
      shreg_nxt   = inBus;
      cnt_nxt     = '0;
      ser_out_nxt = LSB_FIRST ? inBus[0] : inBus[WIDTH-1];
      ser_vld_nxt = 1'b1;
    end else if (state == SHIFT) begin
      if (serLast) begin
        state_nxt   = IDLE;
        shreg_nxt   = '0;
        cnt_nxt     = '0;
        ser_out_nxt = 1'b0;
        ser_vld_nxt = 1'b0;
      end else begin
        // serOut already holds the end bit, so the next bit is one in from the end
        shreg_nxt   = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
        ser_out_nxt = LSB_FIRST ? shreg[1] : shreg[WIDTH-2];
        cnt_nxt     = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      serOut   <= 1'b0;
      serValid <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      cnt      <= cnt_nxt;
      serOut   <= ser_out_nxt;
      serValid <= ser_vld_nxt;
    end
  end

endmodule

// File: tb/tb_trigger_piso_module.sv
// Directed bench for trigger_piso_module: one LSB-first and one MSB-first instance.
module tb_trigger_piso_module;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] inBus, m_inBus;
  logic       inValid, m_inValid;
  logic       inReady, serOut, serValid, serLast, busy;
  logic       m_inReady, m_serOut, m_serValid, m_serLast, m_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trigger_piso_module #(.WIDTH(10), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .inBus(inBus), .inValid(inValid), .inReady(inReady),
    .serOut(serOut), .serValid(serValid), .serLast(serLast), .busy(busy)
  );

  trigger_piso_module #(.WIDTH(10), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .inBus(m_inBus), .inValid(m_inValid), .inReady(m_inReady),
    .serOut(m_serOut), .serValid(m_serValid), .serLast(m_serLast), .busy(m_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle after the accept edge; ends in the last-bit cycle.
  task automatic expect_frame(input string tag, input logic [9:0] w, input bit msb);
    logic eb;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      eb = msb ? w[9-i] : w[i];
      if (msb) begin
        chk($sformatf("%s bit%0d", tag, i), 32'(m_serOut), 32'(eb));
        chk($sformatf("%s vld%0d", tag, i), 32'(m_serValid), 32'd1);
        chk($sformatf("%s last%0d", tag, i), 32'(m_serLast), 32'(i == 9));
        chk($sformatf("%s rdy%0d", tag, i), 32'(m_inReady), 32'(i == 9));
      end else begin
        chk($sformatf("%s bit%0d", tag, i), 32'(serOut), 32'(eb));
        chk($sformatf("%s vld%0d", tag, i), 32'(serValid), 32'd1);
        chk($sformatf("%s last%0d", tag, i), 32'(serLast), 32'(i == 9));
        chk($sformatf("%s rdy%0d", tag, i), 32'(inReady), 32'(i == 9));
        chk($sformatf("%s busy%0d", tag, i), 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, " vld"}, 32'(serValid), 32'd0);
    chk({tag, " out"}, 32'(serOut), 32'd0);
    chk({tag, " last"}, 32'(serLast), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " rdy"}, 32'(inReady), 32'd1);
  endtask

  initial begin
    rst = 1'b0; inBus = 10'h3FF; inValid = 1'b1;
    m_inBus = 10'h000; m_inValid = 1'b0;

    // Reset held with a word offered: nothing starts
    #1;
    expect_idle("rst0");
    for (int c = 0; c < 3; c++) begin
      step();
      expect_idle($sformatf("rst%0d", c + 1));
    end
    rst = 1'b1;
    step();
    inValid = 1'b0;
    expect_frame("post_rst", 10'h3FF, 1'b0);
    step();
    expect_idle("post_rst idle");

    // Single word, LSB first
    inBus = 10'h2B5; inValid = 1'b1;
    step();
    inValid = 1'b0;
    expect_frame("lsb_2B5", 10'h2B5, 1'b0);
    step();
    expect_idle("lsb idle");

    // MSB first
    m_inBus = 10'h001; m_inValid = 1'b1;
    step();
    m_inValid = 1'b0;
    expect_frame("msb_001", 10'h001, 1'b1);
    step();
    chk("msb idle vld", 32'(m_serValid), 32'd0);
    chk("msb idle out", 32'(m_serOut), 32'd0);

    // Back-to-back: 3FF then 000 with no gap
    inBus = 10'h3FF; inValid = 1'b1;
    step();
    inBus = 10'h000;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) step();
      if (c == 11) inValid = 1'b0;
      chk($sformatf("b2b vld%0d", c), 32'(serValid), 32'd1);
      chk($sformatf("b2b out%0d", c), 32'(serOut), 32'(c <= 10));
      chk($sformatf("b2b last%0d", c), 32'(serLast), 32'(c == 10 || c == 20));
      chk($sformatf("b2b rdy%0d", c), 32'(inReady), 32'(c == 10 || c == 20));
    end
    step();
    expect_idle("b2b idle");

    // Mid-frame input change is ignored until the last-bit edge
    inBus = 10'h155; inValid = 1'b1;
    step();
    inValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      if (i == 1) begin
        inBus = 10'h2AA; inValid = 1'b1;
      end
      chk($sformatf("mid bit%0d", i), 32'(serOut), 32'(i % 2 == 0));
      chk($sformatf("mid last%0d", i), 32'(serLast), 32'(i == 9));
      chk($sformatf("mid vld%0d", i), 32'(serValid), 32'd1);
    end
    step();
    inValid = 1'b0;
    expect_frame("mid_2AA", 10'h2AA, 1'b0);
    step();
    expect_idle("mid idle");

    // Reset mid-frame aborts immediately
    inBus = 10'h3FF; inValid = 1'b1;
    step();
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk($sformatf("abort bit%0d", i), 32'(serOut), 32'd1);
    end
    #2;
    rst = 1'b0;
    #1;
    expect_idle("abort now");
    step();
    expect_idle("abort held");
    rst = 1'b1;
    inBus = 10'h001; inValid = 1'b1;
    step();
    inValid = 1'b0;
    expect_frame("after_abort", 10'h001, 1'b0);
    step();
    expect_idle("after_abort idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
